padded_deserializer: RTL
========================

PADDED_DESERIALIZER -- requirements
Module: padded_deserializer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 8: packet width in bits.
REQ-002 SHALL have parameter OUT_WIDTH, default 256: block width in bits; an integer multiple of IN_WIDTH, at least 2 packets.
REQ-003 SHALL have parameter PAD_BEGINNING, default 'h1f: first padding packet (SHAKE256 domain bits).
REQ-004 SHALL have parameter PAD_ENDING, default 'h80: value ORed into the final packet slot of the padded block.
REQ-005 SHALL have ports, clock and reset first:
- clk  input  1  sole clock; all logic on rising edge.
- clear  input  1  synchronous active-high reset.
- in_data  input  IN_WIDTH  message packet.
- in_valid  input  1  in_data valid.
- in_last  input  1  qualifies in_data as the final message packet.
- in_flush  input  1  zero-length message end; no data.
- in_ready  output  1  packet or flush accepted this cycle.
- out_data  output  OUT_WIDTH  assembled block.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts block.
- out_last  output  1  out_data is the final padded block of the message.

Function
REQ-006 SHALL pack packets LSB-first: packet k of a block occupies bits [k*IN_WIDTH +: IN_WIDTH].
REQ-007 SHALL use states FILL, PAD and HOLD; in_ready SHALL be 1 only in FILL.
REQ-008 In FILL, an accepted packet (in_valid & in_ready) SHALL be written to the current slot and the slot counter incremented.
REQ-009 When the last slot is written, the state SHALL be HOLD on the next cycle, with out_valid=1 and out_last=0.
REQ-010 An accepted packet with in_last=1 SHALL enter PAD at the next slot; if it filled the last slot, HOLD SHALL be entered with a pending pad flag.
REQ-011 in_flush accepted in FILL with in_valid=0 SHALL enter PAD at the current slot; in_flush with in_valid=1 SHALL be ignored.
REQ-012 PAD SHALL write one packet per cycle: PAD_BEGINNING in the first pad slot, zero in the others; the last slot SHALL additionally have PAD_ENDING ORed in (0x9f when the first pad slot is also the last).
REQ-013 After PAD writes the last slot, HOLD SHALL be entered with out_last=1.
REQ-014 In HOLD, out_data, out_valid and out_last SHALL stay stable until out_valid & out_ready.
REQ-015 On the handshake: buffer cleared; counter reset to 0; next state PAD if pad pending (pending flag cleared), else FILL.
REQ-016 Block latency: out_valid SHALL rise exactly one cycle after the last slot is written.

Reset
REQ-017 With clear=1 at a clock edge: state FILL, counter 0, buffer 0, pad flag 0, out_valid 0, out_last 0, out_data 0; in_ready SHALL be 1 from the first cycle after clear deasserts.
REQ-018 clear SHALL override every other input in any state, discarding any partial or held block.

Configuration
REQ-019 Macro DESER_PAD_EN: when defined, padding per REQ-010..REQ-013 and REQ-015 is implemented.
REQ-020 When DESER_PAD_EN is undefined: no PAD state, in_flush ignored, PAD_BEGINNING and PAD_ENDING unused; a packet with in_last=1 SHALL close the block immediately with the remaining slots zero and out_last=1.

Verification (IN_WIDTH=8, OUT_WIDTH=32 unless stated)
REQ-021 Packets 0x11, 0x22, 0x33 (in_last on 0x33) -> one block: out_data=32'h9f332211, out_last=1.
REQ-022 Packets 0x01..0x04 (in_last on 0x04) -> blocks 32'h04030201 (out_last=0), then 32'h8000001f (out_last=1).
REQ-023 in_flush from reset -> out_data=32'h8000001f, out_last=1, four cycles after the flush.
REQ-024 out_ready held low for 5 cycles during HOLD -> in_ready=0, out_data stable; a handshake on cycle 6 returns to FILL.
REQ-025 clear after 2 packets, then packets 0xaa, 0xbb, 0xcc, 0xdd -> out_data=32'hddccbbaa, with no stale data.
REQ-026 DESER_PAD_EN undefined: 0x11, 0x22 (in_last on 0x22) -> out_data=32'h00002211, out_last=1.

Source files
------------

// File: rtl/padded_deserializer.sv
`default_nettype none
// ============================================================================
// padded_deserializer
//   Packs IN_WIDTH packets LSB-first into OUT_WIDTH blocks. Define DESER_PAD_EN
//   to append SHAKE-style padding after the final packet or a flush.
// Revision: 1.0 - initial release
// ============================================================================
module padded_deserializer #(
  parameter int                  IN_WIDTH      = 8,
  parameter int                  OUT_WIDTH     = 256,
  parameter logic [IN_WIDTH-1:0] PAD_BEGINNING = 'h1f,
  parameter logic [IN_WIDTH-1:0] PAD_ENDING    = 'h80
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic                 in_flush,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  localparam int            SLOTS     = OUT_WIDTH / IN_WIDTH;
  localparam int            CW        = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(SLOTS - 1);

`ifdef DESER_PAD_EN
  typedef enum logic [1:0] {S_FILL = 2'd0, S_PAD = 2'd1, S_HOLD = 2'd2} state_t;
`else
  typedef enum logic [0:0] {S_FILL = 1'b0, S_HOLD = 1'b1} state_t;
`endif

  state_t                r_state;
  state_t                w_state_next;
  logic [CW-1:0]         r_slot;
  logic [OUT_WIDTH-1:0]  r_data;
  logic                  r_last;
  logic                  w_wr_en;
  logic [IN_WIDTH-1:0]   w_wr_val;
  logic                  w_done;
  logic                  w_set_last;
  logic                  w_at_last;

  assign w_at_last = (r_slot == LAST_SLOT);

`ifdef DESER_PAD_EN
  logic r_pad_pend;
  logic r_pad_first;
  logic w_set_pend;
  logic w_start_pad;
`else
  logic unused_pad_inputs;
  assign unused_pad_inputs = in_flush ^ (^PAD_BEGINNING) ^ (^PAD_ENDING);
`endif

  always_comb begin
    w_state_next = r_state;
    w_wr_en      = 1'b0;
    w_wr_val     = '0;
    w_done       = 1'b0;
    w_set_last   = 1'b0;
`ifdef DESER_PAD_EN
    w_set_pend   = 1'b0;
    w_start_pad  = 1'b0;
`endif
    case (r_state)
      S_FILL: begin
        if (in_valid) begin
          w_wr_en  = 1'b1;
          w_wr_val = in_data;
`ifdef DESER_PAD_EN
          // A final packet in the last slot defers padding to a fresh block.
          if (in_last && w_at_last) begin
            w_state_next = S_HOLD;
            w_set_pend   = 1'b1;
          end else if (in_last) begin
            w_state_next = S_PAD;
            w_start_pad  = 1'b1;
          end else if (w_at_last) begin
            w_state_next = S_HOLD;
          end
        end else if (in_flush) begin
          w_state_next = S_PAD;
          w_start_pad  = 1'b1;
        end
`else
          if (in_last || w_at_last) w_state_next = S_HOLD;
          w_set_last = in_last;
        end
`endif
      end
`ifdef DESER_PAD_EN
      S_PAD: begin
        w_wr_en  = 1'b1;
        w_wr_val = (r_pad_first ? PAD_BEGINNING : '0) | (w_at_last ? PAD_ENDING : '0);
        if (w_at_last) begin
          w_state_next = S_HOLD;
          w_set_last   = 1'b1;
        end
      end
`endif
      S_HOLD: begin
        if (out_ready) begin
          w_done       = 1'b1;
          w_state_next = S_FILL;
`ifdef DESER_PAD_EN
          if (r_pad_pend) begin
            w_state_next = S_PAD;
            w_start_pad  = 1'b1;
          end
`endif
        end
      end
      default: w_state_next = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) r_state <= S_FILL;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (clear || w_done) begin
      r_slot <= '0;
      r_data <= '0;
      r_last <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_data[int'(r_slot) * IN_WIDTH +: IN_WIDTH] <= w_wr_val;
        r_slot <= w_at_last ? '0 : r_slot + 1'b1;
      end
      if (w_set_last) r_last <= 1'b1;
    end
  end

`ifdef DESER_PAD_EN
  always_ff @(posedge clk) begin
    if (clear) begin
      r_pad_pend  <= 1'b0;
      r_pad_first <= 1'b0;
    end else begin
      if (w_done)     r_pad_pend <= 1'b0;
      if (w_set_pend) r_pad_pend <= 1'b1;
      if (w_start_pad)           r_pad_first <= 1'b1;
      else if (r_state == S_PAD) r_pad_first <= 1'b0;
    end
  end
`endif

  assign in_ready  = (r_state == S_FILL);
  assign out_valid = (r_state == S_HOLD);
  assign out_data  = r_data;
  assign out_last  = r_last;

endmodule
`default_nettype wire
